// File: rtl/out_uart_tx.sv
// Serial console for the CPU OUT port: buffers OUT values in a small FIFO,
// renders each as unsigned decimal followed by CR LF, and shifts it out 8N1.
module out_uart_tx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        out_strobe_i,
  input  logic [7:0]                  out_value_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          strobe_prev_q, strobe_prev_d;

  state_e        state_q, state_d;
  logic [7:0]    v_q, v_d;
  logic [1:0]    h_q, h_d;
  logic [3:0]    t_q, t_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;

  logic          push, push_ok, pop;
  logic [2:0]    first_idx;

  // Character slots: 0 hundreds, 1 tens, 2 units, 3 CR, 4 LF.
  function automatic logic [7:0] char_at(input logic [2:0] idx,
                                         input logic [1:0] hund,
                                         input logic [3:0] tens,
                                         input logic [7:0] units);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h30 + {6'd0, hund};
      3'd1:    c = 8'h30 + {4'd0, tens};
      3'd2:    c = 8'h30 + units;
      3'd3:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    strobe_prev_d = out_strobe_i;
    state_d       = state_q;
    v_d           = v_q;
    h_d           = h_q;
    t_d           = t_q;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    bit_d         = bit_q;
    baud_d        = baud_q;
    tx_d          = tx_q;
    pop           = 1'b0;

    push      = out_strobe_i & ~strobe_prev_q;
    push_ok   = push && (count_q < CW'(FIFO_DEPTH));
    first_idx = (h_q != 2'd0) ? 3'd0 : ((t_q != 4'd0) ? 3'd1 : 3'd2);

    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          v_d     = fifo_mem_q[rd_ptr_q];
          h_d     = 2'd0;
          t_d     = 4'd0;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        if (v_q >= 8'd100) begin
          v_d = v_q - 8'd100;
          h_d = h_q + 2'd1;
        end else if (v_q >= 8'd10) begin
          v_d = v_q - 8'd10;
          t_d = t_q + 4'd1;
        end else begin
          idx_d   = first_idx;
          shreg_d = char_at(first_idx, h_q, t_q, v_q);
          baud_d  = BW'(DIV - 1);
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BW'(DIV - 1);
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BW'(DIV - 1);
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_STOP: begin
        if (baud_q == '0) begin
          if (idx_q == 3'd4) begin
            state_d = S_IDLE;
          end else begin
            // Next start bit follows the stop bit directly, no idle gap.
            idx_d   = idx_q + 3'd1;
            shreg_d = char_at(idx_q + 3'd1, h_q, t_q, v_q);
            baud_d  = BW'(DIV - 1);
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  // NOTE: the FIFO storage has no reset; occupancy is tracked by count_q and
  // the pointers, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= out_value_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      strobe_prev_q <= 1'b1;
      state_q       <= S_IDLE;
      v_q           <= 8'd0;
      h_q           <= 2'd0;
      t_q           <= 4'd0;
      idx_q         <= 3'd0;
      shreg_q       <= 8'd0;
      bit_q         <= 3'd0;
      baud_q        <= '0;
      tx_q          <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      strobe_prev_q <= strobe_prev_d;
      state_q       <= state_d;
      v_q           <= v_d;
      h_q           <= h_d;
      t_q           <= t_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      bit_q         <= bit_d;
      baud_q        <= baud_d;
      tx_q          <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (count_q != '0) || (state_q != S_IDLE);

endmodule
